// File: rtl/md_sched_if.sv
// Decode-to-issue handshake between the ID stage and the mul/div issue controller.
// The decoder side drives the i_* fields; the controller answers on the o_* fields.
interface md_sched_if;
    logic       i_valid;
    logic [2:0] i_op_mode;
    logic [4:0] i_rd;
    logic [4:0] i_rs1;
    logic [4:0] i_rs2;
    logic       i_reg_write;
    logic       i_mem_read;
    logic       i_flush;
    logic       o_stall;
    logic       o_issue;
    logic       o_md_start;
    logic [2:0] o_md_op;
    logic [4:0] o_md_rd;
    logic       o_md_busy;
    logic       o_md_wb;

    modport master (
        output i_valid, i_op_mode, i_rd, i_rs1, i_rs2, i_reg_write, i_mem_read, i_flush,
        input  o_stall, o_issue, o_md_start, o_md_op, o_md_rd, o_md_busy, o_md_wb
    );

    modport slave (
        input  i_valid, i_op_mode, i_rd, i_rs1, i_rs2, i_reg_write, i_mem_read, i_flush,
        output o_stall, o_issue, o_md_start, o_md_op, o_md_rd, o_md_busy, o_md_wb
    );
endinterface

// File: rtl/md_sched.sv
// ID->EX issue/hazard controller: sequences the shared iterative mul/div unit, arbitrates
// the register-file write port and detects load-use hazards.
module md_sched #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    md_sched_if.slave   bus
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT - 1) : 1;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 2);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_md_op(input logic [2:0] op);
        return (op == 3'd5) || (op == 3'd6) || (op == 3'd7);
    endfunction

    logic [1:0]       state_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic [4:0]       load_rd_p1;
    logic [2:0]       md_op_p1;
    logic [4:0]       md_rd_p1;
    logic             md_start_p1;

    logic in_flight;
    logic md_done;
    logic rd_hit;
    logic hz_md;
    logic hz_load;
    logic live;
    logic issue;
    logic md_go;
    logic load_go;

    always_comb begin
        in_flight = (state_p1 != ST_IDLE);
        md_done   = (state_p1 == ST_DONE);
        // An rd of x0 never names a real destination, so it cannot create RAW/WAW.
        rd_hit    = (md_rd_p1 != 5'd0) &&
                    ((bus.i_rs1 == md_rd_p1) || (bus.i_rs2 == md_rd_p1) ||
                     (bus.i_reg_write && (bus.i_rd == md_rd_p1)));
        hz_md     = bus.i_valid && in_flight &&
                    (is_md_op(bus.i_op_mode) || rd_hit || (md_done && bus.i_reg_write));
        hz_load   = bus.i_valid && (load_rd_p1 != 5'd0) &&
                    ((bus.i_rs1 == load_rd_p1) || (bus.i_rs2 == load_rd_p1));
        live      = bus.i_valid && !bus.i_flush;
        issue     = live && !(hz_md || hz_load);
        md_go     = issue && is_md_op(bus.i_op_mode);
        load_go   = issue && bus.i_mem_read && bus.i_reg_write;
    end

    assign bus.o_stall    = live && (hz_md || hz_load);
    assign bus.o_issue    = issue;
    assign bus.o_md_start = md_start_p1;
    assign bus.o_md_op    = md_op_p1;
    assign bus.o_md_rd    = md_rd_p1;
    assign bus.o_md_busy  = in_flight;
    assign bus.o_md_wb    = md_done;

    // ID -> EX boundary: sequencer state, latched op and load destination
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_p1    <= ST_IDLE;
            cnt_p1      <= '0;
            load_rd_p1  <= 5'd0;
            md_op_p1    <= 3'd0;
            md_rd_p1    <= 5'd0;
            md_start_p1 <= 1'b0;
        end else begin
            md_start_p1 <= md_go;
            load_rd_p1  <= load_go ? bus.i_rd : 5'd0;
            case (state_p1)
                ST_IDLE: begin
                    if (md_go) begin
                        md_op_p1 <= bus.i_op_mode;
                        md_rd_p1 <= bus.i_rd;
                        cnt_p1   <= (bus.i_op_mode == 3'd5) ? MUL_CNT : DIV_CNT;
                        state_p1 <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_p1 == '0) begin
                        state_p1 <= ST_DONE;
                    end else begin
                        cnt_p1 <= cnt_p1 - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_p1 <= ST_IDLE;
                end
                default: begin
                    state_p1 <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
